line_fill_unit: RTL and testbench

LINE_FILL_UNIT -- requirements
Module: line_fill_unit

---
 rtl/line_fill_unit.sv | 154 +++++++++++++++
 tb/tb_line_fill_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_unit.sv
// Instruction-cache line fill: fetches the four words of a 16-byte line
// from memory, with wait-state tolerance, abort and a per-word timeout.
module line_fill_unit #(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                FillRequest,
    input  logic [ADDR_W-1:0]   FillAddress,
    input  logic                Abort,
    output logic [4*WORD_W-1:0] FillLine,
    output logic                FillValid,
    output logic                FillBusy,
    output logic                FillError,
    output logic [ADDR_W-1:0]   MemoryAddress,
    output logic                MemoryRequest,
    input  logic [WORD_W-1:0]   MemoryBus,
    input  logic                nMemoryWait
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [1:0]          k_q, k_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [4*WORD_W-1:0] line_q, line_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                error_q, error_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    // The line is always 16-byte aligned, so the low address nibble is dropped.
    logic                addr_lsb_unused;
    assign addr_lsb_unused = ^FillAddress[3:0];

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [1:0]        k);
        return base + ADDR_W'({k, 2'b00});
    endfunction

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        tmo_d   = tmo_q;
        line_d  = line_q;
        addr_d  = addr_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        error_d = 1'b0;
        req_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (FillRequest && !Abort) begin
                    state_d = FETCH;
                    base_d  = {FillAddress[ADDR_W-1:4], 4'b0000};
                    k_d     = 2'd0;
                    tmo_d   = '0;
                    addr_d  = {FillAddress[ADDR_W-1:4], 4'b0000};
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                if (Abort) begin
                    // Any word arriving on the abort edge is dropped.
                    state_d = IDLE;
                    k_d     = 2'd0;
                    tmo_d   = '0;
                end else if (nMemoryWait) begin
                    line_d[int'(k_q)*WORD_W +: WORD_W] = MemoryBus;
                    tmo_d  = '0;
                    busy_d = 1'b1;
                    if (k_q == 2'd3) begin
                        state_d = DONE;
                        k_d     = 2'd0;
                        valid_d = 1'b1;
                    end else begin
                        k_d    = k_q + 2'd1;
                        addr_d = word_addr(base_q, k_q + 2'd1);
                        req_d  = 1'b1;
                    end
                end else begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        k_d     = 2'd0;
                        tmo_d   = '0;
                        error_d = 1'b1;
                    end else begin
                        tmo_d  = tmo_q + TW'(1);
                        req_d  = 1'b1;
                        busy_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                k_d     = 2'd0;
                tmo_d   = '0;
            end
        endcase
    end

    // State and output registers; reset overrides every input.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            k_q     <= 2'd0;
            tmo_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            req_q   <= req_d;
        end
    end

    assign FillLine      = line_q;
    assign FillValid     = valid_q;
    assign FillBusy      = busy_q;
    assign FillError     = error_q;
    assign MemoryAddress = addr_q;
    assign MemoryRequest = req_q;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: vector table, directed corner
// sequences and randomized fills against a transaction-level model.
module tb_line_fill_unit;

    localparam int TIMEOUT = 16;

    logic         clock = 1'b0;
    logic         reset, FillRequest, Abort, nMemoryWait;
    logic [31:0]  FillAddress, MemoryAddress, MemoryBus, salt;
    logic [127:0] FillLine, model_line;
    logic         FillValid, FillBusy, FillError, MemoryRequest;
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clock = ~clock;

    // Memory stub: each word's data is its address scrambled by salt.
    assign MemoryBus = MemoryAddress ^ salt;

    line_fill_unit #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .FillRequest(FillRequest),
        .FillAddress(FillAddress), .Abort(Abort), .FillLine(FillLine),
        .FillValid(FillValid), .FillBusy(FillBusy), .FillError(FillError),
        .MemoryAddress(MemoryAddress), .MemoryRequest(MemoryRequest),
        .MemoryBus(MemoryBus), .nMemoryWait(nMemoryWait)
    );

    typedef struct {
        logic [31:0] addr;
        int          w0, w1, w2, w3;
        int          lat;
        bit          err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Cycles from the sampling edge to the FillValid/FillError pulse.
    function automatic int model_latency(input int w[4], output bit err);
        int cycles = 0;
        err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w[k] >= TIMEOUT) begin
                err = 1'b1;
                return cycles + TIMEOUT + 1;
            end
            cycles += w[k] + 1;
        end
        return cycles + 1;
    endfunction

    // Runs one fill from IDLE; w[k] = wait cycles inserted before word k.
    task automatic run_fill(input logic [31:0] addr, input int w[4],
                            input int exp_lat, input bit exp_err);
        logic [31:0] base;
        int          wk;
        int          hold;
        bit          fetching;
        base = {addr[31:4], 4'h0};
        wk   = 0;
        hold = 0;
        FillRequest = 1'b1;
        FillAddress = addr;
        Abort       = 1'b0;
        step();
        FillRequest = 1'b0;
        for (int t = 1; t <= exp_lat + 1; t++) begin
            fetching = (wk < 4) && (t < exp_lat);
            check("valid", {127'd0, FillValid}, {127'd0, (t == exp_lat) && !exp_err});
            check("error", {127'd0, FillError}, {127'd0, (t == exp_lat) && exp_err});
            check("busy", {127'd0, FillBusy}, {127'd0, (t < exp_lat) || ((t == exp_lat) && !exp_err)});
            check("mreq", {127'd0, MemoryRequest}, {127'd0, fetching});
            if (t == exp_lat) begin
                check("line", FillLine, model_line);
            end
            if (fetching) begin
                check("maddr", {96'd0, MemoryAddress}, {96'd0, base + 32'(4 * wk)});
                if (hold == w[wk]) begin
                    nMemoryWait = 1'b1;
                    model_line[wk*32 +: 32] = (base + 32'(4 * wk)) ^ salt;
                    wk++;
                    hold = 0;
                end else begin
                    nMemoryWait = 1'b0;
                    hold++;
                end
            end else begin
                nMemoryWait = 1'($urandom_range(0, 1));
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w[4];
        int          lat;
        bit          err;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0108, 0, 0, 0, 0, 5, 1'b0};
        vecs[1] = '{32'h0000_0108, 0, 0, 3, 0, 8, 1'b0};
        vecs[2] = '{32'hFFFF_FFF4, 0, 0, 0, 0, 5, 1'b0};
        vecs[3] = '{32'h0000_000F, 1, 2, 0, 1, 9, 1'b0};
        vecs[4] = '{32'h1234_5678, 16, 0, 0, 0, 17, 1'b1};
        vecs[5] = '{32'hABCD_EF00, 0, 15, 0, 0, 20, 1'b0};
        vecs[6] = '{32'h0000_0040, 0, 0, 0, 20, 20, 1'b1};
        vecs[7] = '{32'h5555_5550, 2, 0, 0, 16, 22, 1'b1};

        salt = 32'h0;
        reset = 1'b1;
        FillRequest = 1'b0;
        Abort = 1'b0;
        nMemoryWait = 1'b1;
        FillAddress = 32'h0;
        model_line = '0;
        step();
        step();
        check("rst_valid", {127'd0, FillValid}, 128'd0);
        check("rst_busy", {127'd0, FillBusy}, 128'd0);
        check("rst_error", {127'd0, FillError}, 128'd0);
        check("rst_mreq", {127'd0, MemoryRequest}, 128'd0);
        check("rst_maddr", {96'd0, MemoryAddress}, 128'd0);
        check("rst_line", FillLine, 128'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            w = '{vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3};
            run_fill(vecs[i].addr, w, vecs[i].lat, vecs[i].err);
            if (i == 0) begin
                check("line_0x108", FillLine, 128'h0000010C_00000108_00000104_00000100);
            end
        end

        // Abort in FETCH: word arriving on the abort edge must be discarded.
        salt = 32'h5A5A_0000;
        FillRequest = 1'b1;
        FillAddress = 32'h0000_2005;
        nMemoryWait = 1'b1;
        step();
        FillRequest = 1'b0;
        check("ab_mreq1", {127'd0, MemoryRequest}, 128'd1);
        check("ab_maddr0", {96'd0, MemoryAddress}, {96'd0, 32'h0000_2000});
        step();
        check("ab_maddr1", {96'd0, MemoryAddress}, {96'd0, 32'h0000_2004});
        step();
        check("ab_maddr2", {96'd0, MemoryAddress}, {96'd0, 32'h0000_2008});
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        model_line[31:0]  = 32'h0000_2000 ^ salt;
        model_line[63:32] = 32'h0000_2004 ^ salt;
        check("ab_mreq_drop", {127'd0, MemoryRequest}, 128'd0);
        check("ab_busy", {127'd0, FillBusy}, 128'd0);
        check("ab_line", FillLine, model_line);
        step();
        check("ab_novalid", {127'd0, FillValid}, 128'd0);
        w = '{0, 0, 0, 0};
        run_fill(32'h0000_2040, w, 5, 1'b0);

        // Abort together with FillRequest in IDLE: stays idle.
        FillRequest = 1'b1;
        Abort = 1'b1;
        step();
        check("abreq_busy", {127'd0, FillBusy}, 128'd0);
        check("abreq_mreq", {127'd0, MemoryRequest}, 128'd0);
        FillRequest = 1'b0;
        Abort = 1'b0;
        step();

        // FillRequest held during FETCH/DONE is not queued; Abort in DONE keeps the pulse.
        FillRequest = 1'b1;
        FillAddress = 32'h0000_3000;
        step();
        FillAddress = 32'h0000_7770;
        for (int k = 0; k < 4; k++) begin
            check("hold_maddr", {96'd0, MemoryAddress}, {96'd0, 32'h0000_3000 + 32'(4 * k)});
            model_line[k*32 +: 32] = (32'h0000_3000 + 32'(4 * k)) ^ salt;
            step();
        end
        check("hold_valid", {127'd0, FillValid}, 128'd1);
        check("hold_line", FillLine, model_line);
        Abort = 1'b1;
        step();
        check("hold_busy", {127'd0, FillBusy}, 128'd0);
        check("hold_valid0", {127'd0, FillValid}, 128'd0);
        check("hold_line2", FillLine, model_line);
        FillRequest = 1'b0;
        Abort = 1'b0;
        step();

        // Reset mid-fill with FillRequest held high throughout.
        FillRequest = 1'b1;
        FillAddress = 32'h0000_4444;
        step();
        step();
        reset = 1'b1;
        step();
        model_line = '0;
        check("mrst_busy", {127'd0, FillBusy}, 128'd0);
        check("mrst_mreq", {127'd0, MemoryRequest}, 128'd0);
        check("mrst_maddr", {96'd0, MemoryAddress}, 128'd0);
        check("mrst_line", FillLine, 128'd0);
        check("mrst_valid", {127'd0, FillValid | FillError}, 128'd0);
        step();
        check("mrst_busy2", {127'd0, FillBusy}, 128'd0);
        reset = 1'b0;
        step();
        check("mrst_restart", {127'd0, MemoryRequest}, 128'd1);
        check("mrst_maddr2", {96'd0, MemoryAddress}, {96'd0, 32'h0000_4440});
        FillRequest = 1'b0;
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("mrst_discard", FillLine, 128'd0);
        step();

        for (int r = 0; r < 24; r++) begin
            salt = $urandom;
            a = (r == 0) ? 32'hFFFF_FFFC : $urandom;
            for (int k = 0; k < 4; k++) begin
                w[k] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(16, 18))
                                                     : int'($urandom_range(0, 3));
            end
            lat = model_latency(w, err);
            run_fill(a, w, lat, err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
